// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display path.
//   - Active-low segment patterns SEG_0..SEG_F and SEG_BLANK, ordered abcdefg
//     with segment a in bit 6 and segment g in bit 0.
//   - Bit-position constants for the individual segments.
//   - Scan reader FSM state type.
//   - seg7_encode(): nibble -> pattern. The decoder is the exact inverse of this
//     encoder, so both read the same constant table.
package seg7_pkg;

  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  // Active-low: a 0 bit lights the segment.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURED
  } scan_state_e;

  function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nib);
    logic [SEG_W-1:0] pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational active-low abcdefg pattern -> hex nibble.
//   i_seg    [6:0] active-low segment pattern (bit6 = a ... bit0 = g)
//   o_hit          1 when the pattern is one of the sixteen hex glyphs
//   o_nibble [3:0] decoded value; 0 when o_hit is 0
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic             o_hit,
  output logic [3:0]       o_nibble
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_hit    = 1'b1;
    o_nibble = 4'h0;
    case (i_seg)
      SEG_0:   o_nibble = 4'h0;
      SEG_1:   o_nibble = 4'h1;
      SEG_2:   o_nibble = 4'h2;
      SEG_3:   o_nibble = 4'h3;
      SEG_4:   o_nibble = 4'h4;
      SEG_5:   o_nibble = 4'h5;
      SEG_6:   o_nibble = 4'h6;
      SEG_7:   o_nibble = 4'h7;
      SEG_8:   o_nibble = 4'h8;
      SEG_9:   o_nibble = 4'h9;
      SEG_A:   o_nibble = 4'hA;
      SEG_B:   o_nibble = 4'hB;
      SEG_C:   o_nibble = 4'hC;
      SEG_D:   o_nibble = 4'hD;
      SEG_E:   o_nibble = 4'hE;
      SEG_F:   o_nibble = 4'hF;
      default: o_hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers the hex word shown on a scanned 7-segment display.
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_seg   [6:0]       active-low segment bus, bit6 = a ... bit0 = g
//   i_dig_n [DIGITS-1:0] active-low digit strobes, bit0 = least-significant digit
//   o_value [4*DIGITS-1:0] last completed frame, digit i at [4i+3:4i]
//   o_valid             one-cycle pulse when o_value/o_err update
//   o_err               last frame held at least one unrecognized pattern
// A digit is captured once its {seg, dig} pair has been seen unchanged for
// STABLE_CYC synchronized samples; a frame is published once every digit
// position has been captured at least once.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [SEG_W-1:0]      i_seg,
  input  logic [DIGITS-1:0]     i_dig_n,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_valid,
  output logic                  o_err
);

  localparam int               CNT_W   = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SEG_W-1:0]    r_seg_s1, r_seg_s2;
  logic [DIGITS-1:0]   r_dig_s1, r_dig_s2;
  logic [SEG_W-1:0]    r_lat_seg;
  logic [DIGITS-1:0]   r_lat_dig;
  logic [CNT_W-1:0]    r_cnt;
  scan_state_e         r_state;
  logic [DIGITS-1:0]   r_mask;
  logic [4*DIGITS-1:0] r_frame;
  logic                r_ferr;

  logic [DIGITS-1:0]   w_sel;
  logic                w_strobe_ok;
  logic                w_pair_same;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_capture;
  logic                w_hit;
  logic [3:0]          w_nibble;
  logic                w_frame_full;
  logic [DIGITS-1:0]   w_mask_base;
  logic                w_ferr_base;

  // Two-flop synchronizer; reset to all ones = blank display, no digit selected.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_dig_s1 <= '1;
      r_dig_s2 <= '1;
    end else begin
      // NOTE: non-blocking assignments so s2 takes the old s1, giving two real flop stages.
      r_seg_s1 <= i_seg;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= i_dig_n;
      r_dig_s2 <= r_dig_s1;
    end
  end

  // Exactly one strobe low: nonzero and a power of two after inversion.
  assign w_sel       = ~r_dig_s2;
  assign w_strobe_ok = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_pair_same = (r_seg_s2 == r_lat_seg) && (r_dig_s2 == r_lat_dig);
  assign w_cnt_next  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  // Capture fires on the edge that records the STABLE_CYC-th identical sample.
  assign w_capture   = (r_state == ST_SETTLE) && w_pair_same && (w_cnt_next == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lat_seg <= '1;
      r_lat_dig <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe_ok) begin
            r_state   <= ST_SETTLE;
            r_cnt     <= CNT_ONE;
            r_lat_seg <= r_seg_s2;
            r_lat_dig <= r_dig_s2;
          end
        end
        ST_SETTLE, ST_CAPTURED: begin
          if (w_pair_same) begin
            // CAPTURED simply holds: an unchanged pair is never captured twice.
            if (r_state == ST_SETTLE) begin
              r_cnt <= w_cnt_next;
              if (w_capture) r_state <= ST_CAPTURED;
            end
          end else if (w_strobe_ok) begin
            r_state   <= ST_SETTLE;
            r_cnt     <= CNT_ONE;
            r_lat_seg <= r_seg_s2;
            r_lat_dig <= r_dig_s2;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  seg7_pattern_decode u_decode (
    .i_seg    (r_lat_seg),
    .o_hit    (w_hit),
    .o_nibble (w_nibble)
  );

  // Publishing a full frame clears mask/error in the same edge; a capture on
  // that edge is folded into the cleared state so it starts the next frame.
  assign w_frame_full = &r_mask;
  assign w_mask_base  = w_frame_full ? '0 : r_mask;
  assign w_ferr_base  = w_frame_full ? 1'b0 : r_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask  <= '0;
      r_ferr  <= 1'b0;
      r_frame <= '0;
      o_value <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= w_frame_full;
      if (w_frame_full) begin
        o_value <= r_frame;
        o_err   <= r_ferr;
      end
      if (w_capture) begin
        r_mask <= w_mask_base | ~r_lat_dig;
        r_ferr <= w_ferr_base | ~w_hit;
        for (int i = 0; i < DIGITS; i++) begin
          if (!r_lat_dig[i]) r_frame[4*i +: 4] <= w_nibble;
        end
      end else begin
        r_mask <= w_mask_base;
        r_ferr <= w_ferr_base;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed bench for seg7_scan_reader (DIGITS=4, STABLE_CYC=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// and o_valid pulses are counted 1 ns after each rising edge.
module tb_seg7_scan_reader;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001;
  localparam logic [6:0] PD = 7'b1000010;
  localparam logic [6:0] PE = 7'b0110000;
  localparam logic [6:0] PF = 7'b0111000;
  localparam logic [6:0] PBLANK = 7'b1111111;
  localparam logic [6:0] PDASH  = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic        valid;
  logic        err;

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int consec    = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_seg   (seg),
    .i_dig_n (dig_n),
    .o_value (value),
    .o_valid (valid),
    .o_err   (err)
  );

  always @(posedge clk) begin
    #1;
    if (valid) begin
      valid_cnt++;
      if (prev_valid) consec++;
    end
    prev_valid = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive digit d with pattern p for n cycles; always entered on a falling edge.
  task automatic show(input int d, input logic [6:0] p, input int n);
    dig_n = ~(4'b0001 << d);
    seg   = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input logic [3:0] dn, input int n);
    dig_n = dn;
    seg   = P8;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    show(0, p0, 10);
    show(1, p1, 10);
    show(2, p2, 10);
    show(3, p3, 10);
    gap(4'b1111, 5);
  endtask

  task automatic frame_check(input string tag, input int v0,
                             input logic [15:0] ev, input logic ee);
    check({tag, "_pulses"}, valid_cnt, v0 + 1);
    check({tag, "_value"}, value, ev);
    check({tag, "_err"}, err, ee);
  endtask

  initial begin
    int v0;
    rst_n = 1'b0;
    seg   = PBLANK;
    dig_n = 4'b1111;

    // Reset with random inputs.
    repeat (4) begin
      @(negedge clk);
      seg   = 7'($urandom);
      dig_n = 4'($urandom);
      check("rst_value", value, 16'h0);
      check("rst_valid", valid, 1'b0);
      check("rst_err", err, 1'b0);
    end
    seg   = PBLANK;
    dig_n = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_valid", valid_cnt, 0);

    // Clean scan 1,2,A,F with an exact latency check on the completing digit.
    v0 = valid_cnt;
    show(0, P1, 10);
    show(1, P2, 10);
    show(2, PA, 10);
    dig_n = 4'b0111;
    seg   = PF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("latency_k%0d", k), valid, (k == 7) ? 1'b1 : 1'b0);
    end
    repeat (2) @(negedge clk);
    gap(4'b1111, 5);
    frame_check("clean", v0, 16'hFA21, 1'b0);

    // Invalid-glyph glitch on digit 2 held only 3 samples, then the real glyph.
    v0 = valid_cnt;
    show(0, P3, 10);
    show(1, P4, 10);
    show(2, PDASH, 3);
    show(2, P5, 8);
    show(3, P6, 10);
    gap(4'b1111, 5);
    frame_check("glitch", v0, 16'h6543, 1'b0);

    // Blank pattern on digit 1 flags the frame and decodes as 0.
    v0 = valid_cnt;
    scan4(P7, PBLANK, P9, PC);
    frame_check("invalid", v0, 16'hC907, 1'b1);

    v0 = valid_cnt;
    scan4(P8, P0, PB, PD);
    frame_check("recover", v0, 16'hDB08, 1'b0);

    // Invalid strobe combinations between digits must not capture.
    v0 = valid_cnt;
    show(0, PE, 10);
    gap(4'b1111, 10);
    show(1, P2, 10);
    dig_n = 4'b0011;
    seg   = P7;
    repeat (10) @(negedge clk);
    check("badstrobe_no_early_frame", valid_cnt, v0);
    show(2, P3, 10);
    show(3, P4, 10);
    gap(4'b1111, 5);
    frame_check("badstrobe", v0, 16'h432E, 1'b0);

    // Reset after two captures discards the partial frame.
    v0 = valid_cnt;
    show(0, P9, 10);
    show(1, P9, 10);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_value", value, 16'h0);
    check("midrst_valid", valid, 1'b0);
    check("midrst_err", err, 1'b0);
    dig_n = 4'b1111;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    show(2, PA, 10);
    show(3, P5, 10);
    gap(4'b1111, 5);
    check("midrst_two_captures_no_frame", valid_cnt, v0);
    show(0, P1, 10);
    show(1, P0, 10);
    gap(4'b1111, 5);
    frame_check("midrst", v0, 16'h5A01, 1'b0);

    check("valid_single_cycle", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
